oagu_stride_wr: RTL and testbench
=================================

Name: oagu_stride_wr

Overview:
- Parametrised output address generation unit, successor to the single-stream OAGU.
- Accepts result beats from the XPE array over a valid/ready stream and buffers them in a small FIFO.
- Writes each beat to the IO buffer at addresses produced by store/jump stride rules.
- Beats are interleaved round-robin over up to NUM_DST destination regions, which generalises the dot/dot-acc dual-address mode.
- Supports write-side backpressure.

Parameters:
- DATA_W, 256, beat width.
- ADDR_W, 16, IO buffer address width; address arithmetic is modulo 2^ADDR_W.
- CNT_W, 8, width of the x/y/layer/store/jump counters and lengths.
- NUM_DST, 2, maximum number of destination regions (at least 1).
- FIFO_DEPTH, 4, depth of the output buffering FIFO (a power of 2, at least 2).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle pulse; latches all i_cfg_* inputs.
- i_cfg_base  in  NUM_DST*ADDR_W  start address per destination; destination d is at [d*ADDR_W +: ADDR_W].
- i_cfg_dst_cnt  in  clog2(NUM_DST)+1  number of active destinations, 1..NUM_DST.
- i_cfg_x_len  in  CNT_W  groups per row.
- i_cfg_layers  in  CNT_W  output layers (pieces) per row.
- i_cfg_y_len  in  CNT_W  rows.
- i_cfg_store_len  in  CNT_W  groups written contiguously before a jump; 0 means never jump.
- i_cfg_jump_len  in  CNT_W  address increment applied at a jump (zero-extended).
- i_dat  in  DATA_W  result beat.
- i_dat_vld  in  1  beat valid.
- o_dat_rdy  out  1  beat accepted when i_dat_vld and o_dat_rdy are both high.
- o_wr_en  out  1  IO buffer write request.
- i_wr_rdy  in  1  IO buffer accepts the write this cycle.
- o_waddr  out  ADDR_W  write address.
- o_wdat  out  DATA_W  write data.
- o_wsel  out  1  bank select, equal to o_waddr[ADDR_W-4].
- o_busy  out  1  high from the cycle after i_start until done.
- o_done  out  1  sticky; cleared by the next i_start.

Behaviour:
- Reset values: every output is 0; FSM in IDLE; FIFO empty; all counters 0.
- FSM states:
  - IDLE to RUN on i_start.
  - i_start with any of x_len, layers, y_len or dst_cnt equal to 0 goes to DONE directly; no writes occur.
  - RUN to DRAIN when the last input beat is accepted.
  - DRAIN to DONE when the FIFO is empty and the final write has handshaken.
  - DONE to RUN on i_start.
  - i_start in RUN or DRAIN is ignored.
- Total input beats = x_len * layers * y_len * dst_cnt.
- o_dat_rdy = (state == RUN) and FIFO not full.
  - After the last beat is accepted, o_dat_rdy is low.
  - Extra input beats are never accepted.
- Each FIFO entry stores the beat plus its computed address. o_wr_en is high whenever the FIFO is non-empty.
- A write completes when o_wr_en and i_wr_rdy are both high.
- o_wr_en, o_waddr and o_wdat are held stable while i_wr_rdy is low.
- Latency: a beat accepted in cycle N is presented on the write port in cycle N+1 at the earliest.
- Simultaneous push and pop on a full FIFO is not allowed; o_dat_rdy is low when the FIFO is full.
- Destination index:
  - dst_idx cycles 0..dst_cnt-1, one step per accepted beat.
  - A beat's address is addr[dst_idx].
  - A group is dst_cnt consecutive beats.
- At the last beat of a group, every addr[d] advances:
  - by +1 if store_len == 0 or store_cnt+1 != store_len; store_cnt then increments;
  - by +jump_len if store_cnt+1 == store_len; store_cnt then returns to 0.
- Counters, per completed group:
  - x_cnt increments and wraps at x_len.
  - On x wrap, piece_cnt increments and wraps at layers.
  - On piece wrap, y_cnt increments.
  - The last group is the one where x, piece and y are all at their last value.
- o_done rises in the cycle after the final write handshake; o_busy falls in the same cycle.
- Reset asserted mid-operation discards FIFO contents and returns the block to IDLE.

Optional Feature:
- Macro: OAGU_BOUND_CHK_EN.
- Adds input i_cfg_limit (ADDR_W, latched on i_start) and output o_oob_err (sticky, reset 0, cleared by i_start).
- When the macro is defined:
  - a beat whose computed address is >= limit is still accepted but is not pushed to the FIFO;
  - such a beat sets o_oob_err;
  - counters and addresses still advance normally.
- When the macro is not defined, the port and check are absent and every beat is written.

Test Plan:
- dst_cnt=1, base0=0x0100, x=4, layers=1, y=1, store=0, i_wr_rdy=1 → writes to 0x100,0x101,0x102,0x103; o_done asserted one cycle after the 4th write.
- dst_cnt=1, base0=0, x=6, layers=1, y=1, store=2, jump=8 → addresses 0,1,9,10,18,19.
- dst_cnt=2, base0=0x0000, base1=0x1000, x=2, layers=1, y=1 → writes 0x0000,0x1000,0x0001,0x1001; o_wsel=0,1,0,1.
- Same as the first scenario, with i_wr_rdy held low for 10 cycles → o_dat_rdy drops after FIFO_DEPTH beats; outputs are held stable; no beat is lost or duplicated; o_done comes after the 4th write.
- y_len=0 on i_start → DONE next cycle; o_wr_en never asserts. In a separate run, reset asserted mid-RUN → all outputs return to 0.
- OAGU_BOUND_CHK_EN with limit=0x0102 and the first scenario → only 0x100 and 0x101 are written; o_oob_err=1; o_done still asserts.

Source files
------------

// File: rtl/oagu_stride_wr.sv
// Output address generator: buffers result beats in a small FIFO and writes them to the IO buffer
// using store/jump strides interleaved over up to NUM_DST regions. Optional macro: OAGU_BOUND_CHK_EN.
module oagu_stride_wr #(
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 16,
    parameter int CNT_W      = 8,
    parameter int NUM_DST    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [NUM_DST*ADDR_W-1:0] i_cfg_base,
    input  logic [$clog2(NUM_DST):0]  i_cfg_dst_cnt,
    input  logic [CNT_W-1:0]          i_cfg_x_len,
    input  logic [CNT_W-1:0]          i_cfg_layers,
    input  logic [CNT_W-1:0]          i_cfg_y_len,
    input  logic [CNT_W-1:0]          i_cfg_store_len,
    input  logic [CNT_W-1:0]          i_cfg_jump_len,
`ifdef OAGU_BOUND_CHK_EN
    input  logic [ADDR_W-1:0]         i_cfg_limit,
    output logic                      o_oob_err,
`endif
    input  logic [DATA_W-1:0]         i_dat,
    input  logic                      i_dat_vld,
    output logic                      o_dat_rdy,
    output logic                      o_wr_en,
    input  logic                      i_wr_rdy,
    output logic [ADDR_W-1:0]         o_waddr,
    output logic [DATA_W-1:0]         o_wdat,
    output logic                      o_wsel,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int DCW = $clog2(NUM_DST) + 1;
    localparam int DIW = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int FCW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [ADDR_W-1:0]  r_addr [NUM_DST];
    logic [DCW-1:0]     r_dst_cnt;
    logic [DIW-1:0]     r_dst_idx;
    logic [CNT_W-1:0]   r_x_len, r_layers, r_y_len, r_store_len, r_jump_len;
    logic [CNT_W-1:0]   r_x_cnt, r_piece_cnt, r_y_cnt, r_store_cnt;

    logic [ADDR_W-1:0]  r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_fifo_dat  [FIFO_DEPTH];
    logic [PW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [FCW-1:0]     r_fifo_cnt;

    logic [ADDR_W-1:0]  w_base [NUM_DST];
    logic               w_full, w_empty, w_acc, w_push, w_pop;
    logic               w_grp_last, w_x_last, w_piece_last, w_y_last, w_last_grp;
    logic               w_jump, w_cfg_zero;
    logic [ADDR_W-1:0]  w_inc, w_cur_addr;
    logic [DCW-1:0]     w_dst_cnt_sat;
    logic [FCW-1:0]     w_cnt_next;

    for (genvar gi = 0; gi < NUM_DST; gi++) begin : g_base
        assign w_base[gi] = i_cfg_base[gi*ADDR_W +: ADDR_W];
    end

    assign w_full     = (r_fifo_cnt == FCW'(FIFO_DEPTH));
    assign w_empty    = (r_fifo_cnt == '0);
    assign o_dat_rdy  = (r_state == S_RUN) && !w_full;
    assign w_acc      = i_dat_vld && o_dat_rdy;
    assign w_pop      = !w_empty && i_wr_rdy;
    assign w_cur_addr = r_addr[r_dst_idx];

    assign w_grp_last   = ((DCW'(r_dst_idx) + DCW'(1)) == r_dst_cnt);
    assign w_x_last     = (r_x_cnt == r_x_len - CNT_W'(1));
    assign w_piece_last = (r_piece_cnt == r_layers - CNT_W'(1));
    assign w_y_last     = (r_y_cnt == r_y_len - CNT_W'(1));
    assign w_last_grp   = w_grp_last && w_x_last && w_piece_last && w_y_last;

    // store_len == 0 disables jumping entirely
    assign w_jump = (r_store_len != '0) && ((r_store_cnt + CNT_W'(1)) == r_store_len);
    assign w_inc  = w_jump ? ADDR_W'(r_jump_len) : ADDR_W'(1);

    assign w_cfg_zero = (i_cfg_x_len == '0) || (i_cfg_layers == '0) ||
                        (i_cfg_y_len == '0) || (i_cfg_dst_cnt == '0);
    assign w_dst_cnt_sat = (i_cfg_dst_cnt > DCW'(NUM_DST)) ? DCW'(NUM_DST) : i_cfg_dst_cnt;

`ifdef OAGU_BOUND_CHK_EN
    logic [ADDR_W-1:0] r_limit;
    logic              r_oob_err;
    logic              w_oob;
    assign w_oob     = (w_cur_addr >= r_limit);
    assign w_push    = w_acc && !w_oob;
    assign o_oob_err = r_oob_err;
`else
    assign w_push    = w_acc;
`endif

    assign w_cnt_next = r_fifo_cnt + FCW'(w_push) - FCW'(w_pop);

    assign o_wr_en = !w_empty;
    assign o_waddr = w_empty ? '0 : r_fifo_addr[r_rd_ptr];
    assign o_wdat  = w_empty ? '0 : r_fifo_dat[r_rd_ptr];
    assign o_wsel  = o_waddr[ADDR_W-4];
    assign o_busy  = r_busy;
    assign o_done  = r_done;

    // Storage needs no reset: the write port is forced to zero while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= w_cur_addr;
            r_fifo_dat[r_wr_ptr]  <= i_dat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_fifo_cnt <= w_cnt_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dst_cnt   <= '0;
            r_dst_idx   <= '0;
            r_x_len     <= '0;
            r_layers    <= '0;
            r_y_len     <= '0;
            r_store_len <= '0;
            r_jump_len  <= '0;
            r_x_cnt     <= '0;
            r_piece_cnt <= '0;
            r_y_cnt     <= '0;
            r_store_cnt <= '0;
            for (int d = 0; d < NUM_DST; d++) r_addr[d] <= '0;
`ifdef OAGU_BOUND_CHK_EN
            r_limit     <= '0;
            r_oob_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_dst_cnt   <= w_dst_cnt_sat;
                        r_x_len     <= i_cfg_x_len;
                        r_layers    <= i_cfg_layers;
                        r_y_len     <= i_cfg_y_len;
                        r_store_len <= i_cfg_store_len;
                        r_jump_len  <= i_cfg_jump_len;
                        r_dst_idx   <= '0;
                        r_x_cnt     <= '0;
                        r_piece_cnt <= '0;
                        r_y_cnt     <= '0;
                        r_store_cnt <= '0;
                        for (int d = 0; d < NUM_DST; d++) r_addr[d] <= w_base[d];
`ifdef OAGU_BOUND_CHK_EN
                        r_limit     <= i_cfg_limit;
                        r_oob_err   <= 1'b0;
`endif
                        if (w_cfg_zero) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (w_acc) begin
`ifdef OAGU_BOUND_CHK_EN
                        if (w_oob) r_oob_err <= 1'b1;
`endif
                        if (w_grp_last) begin
                            r_dst_idx   <= '0;
                            for (int d = 0; d < NUM_DST; d++) r_addr[d] <= r_addr[d] + w_inc;
                            r_store_cnt <= w_jump ? '0 : r_store_cnt + CNT_W'(1);
                            r_x_cnt     <= w_x_last ? '0 : r_x_cnt + CNT_W'(1);
                            if (w_x_last) r_piece_cnt <= w_piece_last ? '0 : r_piece_cnt + CNT_W'(1);
                            if (w_x_last && w_piece_last) r_y_cnt <= r_y_cnt + CNT_W'(1);
                        end else begin
                            r_dst_idx <= r_dst_idx + DIW'(1);
                        end
                        // A dropped final beat with nothing left to write finishes immediately
                        if (w_last_grp) begin
                            if (w_cnt_next == '0) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_cnt_next == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oagu_stride_wr.sv
// Scoreboard bench for oagu_stride_wr: scenarios queue expected writes, a monitor pops and compares.
module tb_oagu_stride_wr;
    localparam int DATA_W = 256, ADDR_W = 16, CNT_W = 8, NUM_DST = 2, FIFO_DEPTH = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } exp_t;

    logic                      i_clk = 1'b0;
    logic                      i_rst_n;
    logic                      i_start;
    logic [NUM_DST*ADDR_W-1:0] i_cfg_base;
    logic [1:0]                i_cfg_dst_cnt;
    logic [CNT_W-1:0]          i_cfg_x_len, i_cfg_layers, i_cfg_y_len, i_cfg_store_len, i_cfg_jump_len;
    logic [DATA_W-1:0]         i_dat;
    logic                      i_dat_vld;
    logic                      o_dat_rdy;
    logic                      o_wr_en;
    logic                      i_wr_rdy;
    logic [ADDR_W-1:0]         o_waddr;
    logic [DATA_W-1:0]         o_wdat;
    logic                      o_wsel;
    logic                      o_busy;
    logic                      o_done;
`ifdef OAGU_BOUND_CHK_EN
    logic [ADDR_W-1:0]         i_cfg_limit;
    logic                      o_oob_err;
`endif

    exp_t exp_q[$];
    int n_cmp = 0, n_err = 0, cyc = 0, n_acc = 0;
    int last_hs_cyc = -10, done_rise_cyc = -20;

    oagu_stride_wr #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .NUM_DST(NUM_DST), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_cfg_base(i_cfg_base), .i_cfg_dst_cnt(i_cfg_dst_cnt),
        .i_cfg_x_len(i_cfg_x_len), .i_cfg_layers(i_cfg_layers), .i_cfg_y_len(i_cfg_y_len),
        .i_cfg_store_len(i_cfg_store_len), .i_cfg_jump_len(i_cfg_jump_len),
`ifdef OAGU_BOUND_CHK_EN
        .i_cfg_limit(i_cfg_limit), .o_oob_err(o_oob_err),
`endif
        .i_dat(i_dat), .i_dat_vld(i_dat_vld), .o_dat_rdy(o_dat_rdy),
        .o_wr_en(o_wr_en), .i_wr_rdy(i_wr_rdy), .o_waddr(o_waddr), .o_wdat(o_wdat),
        .o_wsel(o_wsel), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    function automatic logic [DATA_W-1:0] mk(int sid, int i);
        return {8'(sid), 8'(i), 224'(0), 8'(sid), 8'(i)};
    endfunction

    task automatic check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        exp_q.push_back('{addr: a, dat: d});
    endtask

    // Monitor: compares every write handshake and checks holding under backpressure
    initial begin
        logic stall_prev = 1'b0, done_prev = 1'b0;
        logic [ADDR_W-1:0] pa = '0;
        logic [DATA_W-1:0] pd = '0;
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (stall_prev && i_rst_n) begin
                check("hold_wr_en", DATA_W'(o_wr_en), DATA_W'(1));
                check("hold_addr", DATA_W'(o_waddr), DATA_W'(pa));
                check("hold_dat", o_wdat, pd);
            end
            if (o_wr_en && i_wr_rdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0h, required no write", o_waddr);
                end else begin
                    e = exp_q.pop_front();
                    $display("wr addr=%h wsel=%0d dat_lo=%h", o_waddr, o_wsel, o_wdat[15:0]);
                    check("waddr", DATA_W'(o_waddr), DATA_W'(e.addr));
                    check("wdat", o_wdat, e.dat);
                    check("wsel", DATA_W'(o_wsel), DATA_W'(e.addr[ADDR_W-4]));
                    last_hs_cyc = cyc;
                end
            end
            if (o_done && !done_prev) done_rise_cyc = cyc;
            done_prev  = o_done;
            stall_prev = o_wr_en && !i_wr_rdy && i_rst_n;
            pa = o_waddr;
            pd = o_wdat;
        end
    end

    task automatic start(int dst, logic [ADDR_W-1:0] b0, logic [ADDR_W-1:0] b1,
                         int x, int l, int y, int st, int jmp);
        @(posedge i_clk);
        #1;
        i_cfg_dst_cnt   = 2'(dst);
        i_cfg_base      = {b1, b0};
        i_cfg_x_len     = CNT_W'(x);
        i_cfg_layers    = CNT_W'(l);
        i_cfg_y_len     = CNT_W'(y);
        i_cfg_store_len = CNT_W'(st);
        i_cfg_jump_len  = CNT_W'(jmp);
        i_start         = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic send(int sid, int n);
        for (int i = 0; i < n; i++) begin
            logic r;
            int t = 0;
            i_dat_vld = 1'b1;
            i_dat     = mk(sid, i);
            do begin
                @(negedge i_clk);
                r = o_dat_rdy;
                @(posedge i_clk);
                #1;
                t++;
            end while (!r && t < 200);
            if (!r) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: got no accept of beat %0d, required accept", i);
                i_dat_vld = 1'b0;
                return;
            end
            n_acc++;
        end
        i_dat_vld = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge i_clk);
        while (!o_done && t < 300) begin
            @(negedge i_clk);
            t++;
        end
        #1;
        check("done_seen", DATA_W'(o_done), DATA_W'(1));
        check("done_timing", DATA_W'(done_rise_cyc), DATA_W'(last_hs_cyc + 1));
        check("busy_low", DATA_W'(o_busy), DATA_W'(0));
        check("queue_drained", DATA_W'(exp_q.size()), DATA_W'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_dat_vld = 1'b0; i_dat = '0; i_wr_rdy = 1'b1;
        i_cfg_base = '0; i_cfg_dst_cnt = '0; i_cfg_x_len = '0; i_cfg_layers = '0;
        i_cfg_y_len = '0; i_cfg_store_len = '0; i_cfg_jump_len = '0;
`ifdef OAGU_BOUND_CHK_EN
        i_cfg_limit = '1;
`endif
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_wr_en", DATA_W'(o_wr_en), DATA_W'(0));
        check("rst_dat_rdy", DATA_W'(o_dat_rdy), DATA_W'(0));
        check("rst_busy", DATA_W'(o_busy), DATA_W'(0));
        check("rst_done", DATA_W'(o_done), DATA_W'(0));
        check("rst_waddr", DATA_W'(o_waddr), DATA_W'(0));
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Contiguous single destination, then extra beats must be refused
        for (int i = 0; i < 4; i++) expect_wr(16'h0100 + 16'(i), mk(1, i));
        start(1, 16'h0100, 16'h0, 4, 1, 1, 0, 0);
        check("busy_high", DATA_W'(o_busy), DATA_W'(1));
        send(1, 4);
        i_dat_vld = 1'b1;
        i_dat     = mk(1, 9);
        repeat (3) begin
            @(negedge i_clk);
            check("no_extra_rdy", DATA_W'(o_dat_rdy), DATA_W'(0));
        end
        i_dat_vld = 1'b0;
        wait_done();

        // Store 2 then jump 8
        expect_wr(16'd0, mk(2, 0));  expect_wr(16'd1, mk(2, 1));
        expect_wr(16'd9, mk(2, 2));  expect_wr(16'd10, mk(2, 3));
        expect_wr(16'd18, mk(2, 4)); expect_wr(16'd19, mk(2, 5));
        start(1, 16'h0, 16'h0, 6, 1, 1, 2, 8);
        send(2, 6);
        wait_done();

        // Two destinations interleaved
        expect_wr(16'h0000, mk(3, 0)); expect_wr(16'h1000, mk(3, 1));
        expect_wr(16'h0001, mk(3, 2)); expect_wr(16'h1001, mk(3, 3));
        start(2, 16'h0000, 16'h1000, 2, 1, 1, 0, 0);
        send(3, 4);
        wait_done();

        // Layers and rows with store 3 / jump 0x10
        expect_wr(16'h20, mk(6, 0)); expect_wr(16'h21, mk(6, 1));
        expect_wr(16'h22, mk(6, 2)); expect_wr(16'h32, mk(6, 3));
        expect_wr(16'h33, mk(6, 4)); expect_wr(16'h34, mk(6, 5));
        expect_wr(16'h44, mk(6, 6)); expect_wr(16'h45, mk(6, 7));
        start(1, 16'h0020, 16'h0, 2, 2, 2, 3, 16);
        send(6, 8);
        wait_done();

        // Write backpressure for 10 cycles
        for (int i = 0; i < 6; i++) expect_wr(16'h0100 + 16'(i), mk(4, i));
        i_wr_rdy = 1'b0;
        n_acc = 0;
        start(1, 16'h0100, 16'h0, 6, 1, 1, 0, 0);
        fork
            send(4, 6);
            begin
                repeat (10) @(posedge i_clk);
                @(negedge i_clk);
                check("bp_acc_cnt", DATA_W'(n_acc), DATA_W'(FIFO_DEPTH));
                check("bp_rdy_low", DATA_W'(o_dat_rdy), DATA_W'(0));
                @(posedge i_clk);
                #1;
                i_wr_rdy = 1'b1;
            end
        join
        wait_done();

        // Zero y_len: straight to done, no writes
        start(1, 16'h0100, 16'h0, 4, 1, 0, 0, 0);
        check("zero_done", DATA_W'(o_done), DATA_W'(1));
        check("zero_busy", DATA_W'(o_busy), DATA_W'(0));
        repeat (4) begin
            @(negedge i_clk);
            check("zero_no_wr", DATA_W'(o_wr_en), DATA_W'(0));
        end

        // Reset in the middle of a run
        i_wr_rdy = 1'b0;
        for (int i = 0; i < 2; i++) expect_wr(16'h0100 + 16'(i), mk(7, i));
        start(1, 16'h0100, 16'h0, 6, 1, 1, 0, 0);
        send(7, 2);
        @(negedge i_clk);
        check("mid_wr_en", DATA_W'(o_wr_en), DATA_W'(1));
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check("mrst_wr_en", DATA_W'(o_wr_en), DATA_W'(0));
        check("mrst_dat_rdy", DATA_W'(o_dat_rdy), DATA_W'(0));
        check("mrst_busy", DATA_W'(o_busy), DATA_W'(0));
        check("mrst_done", DATA_W'(o_done), DATA_W'(0));
        check("mrst_waddr", DATA_W'(o_waddr), DATA_W'(0));
        check("mrst_wdat", o_wdat, DATA_W'(0));
        check("mrst_wsel", DATA_W'(o_wsel), DATA_W'(0));
        exp_q.delete();
        @(posedge i_clk);
        #1;
        i_rst_n  = 1'b1;
        i_wr_rdy = 1'b1;

        // Recovery after reset
        expect_wr(16'h0000, mk(8, 0)); expect_wr(16'h1000, mk(8, 1));
        expect_wr(16'h0001, mk(8, 2)); expect_wr(16'h1001, mk(8, 3));
        start(2, 16'h0000, 16'h1000, 2, 1, 1, 0, 0);
        send(8, 4);
        wait_done();

`ifdef OAGU_BOUND_CHK_EN
        // Bound check: addresses at or above the limit are dropped
        expect_wr(16'h0100, mk(9, 0)); expect_wr(16'h0101, mk(9, 1));
        i_cfg_limit = 16'h0102;
        start(1, 16'h0100, 16'h0, 4, 1, 1, 0, 0);
        check("oob_clear", DATA_W'(o_oob_err), DATA_W'(0));
        send(9, 4);
        wait_done();
        check("oob_set", DATA_W'(o_oob_err), DATA_W'(1));
        i_cfg_limit = '1;
`endif

        repeat (3) @(posedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
